// File: rtl/param_reg_file_pkg.sv
// regfile_pkg: shared default sizes, tap indices and address type for the register file
package regfile_pkg;
    localparam int DEF_W    = 16;
    localparam int DEF_AW   = 3;
    localparam int DEF_SW   = 2;
    localparam int DEF_TAP0 = 0;
    localparam int DEF_TAP1 = 3;
    localparam int DEF_TAP2 = 4;
    typedef logic [DEF_AW-1:0] reg_addr_t;
endpackage

// File: rtl/param_reg_file_if.sv
// param_reg_file_if: write, issue, status and read signals of the register file
interface param_reg_file_if
    import regfile_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int AW = DEF_AW,
    parameter int SW = DEF_SW
);
    logic          WeA;
    logic [AW-1:0] WaddrA;
    logic [W-1:0]  WdataA;
    logic          WeB;
    logic [AW-1:0] WaddrB;
    logic [W-1:0]  WdataB;
    logic          StEn;
    logic [SW-1:0] StIn;
    logic          IssueEn;
    logic [AW-1:0] IssueAddr;
    logic [AW-1:0] RaddrA;
    logic [AW-1:0] RaddrB;
    logic [W-1:0]  DataOutA;
    logic [W-1:0]  DataOutB;
    logic [W-1:0]  Tap0;
    logic [W-1:0]  Tap1;
    logic [W-1:0]  Tap2;
    logic          PendA;
    logic          PendB;
    logic          Busy;
    logic [SW-1:0] S;

    modport master (
        output WeA, WaddrA, WdataA, WeB, WaddrB, WdataB, StEn, StIn,
               IssueEn, IssueAddr, RaddrA, RaddrB,
        input  DataOutA, DataOutB, Tap0, Tap1, Tap2, PendA, PendB, Busy, S
    );

    modport slave (
        input  WeA, WaddrA, WdataA, WeB, WaddrB, WdataB, StEn, StIn,
               IssueEn, IssueAddr, RaddrA, RaddrB,
        output DataOutA, DataOutB, Tap0, Tap1, Tap2, PendA, PendB, Busy, S
    );
endinterface

// File: rtl/param_reg_file_scoreboard.sv
// rf_scoreboard: one pending bit per register for outstanding deferred writes
module rf_scoreboard #(
    parameter int AW = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we_a,
    input  logic [AW-1:0] i_waddr_a,
    input  logic          i_we_b,
    input  logic [AW-1:0] i_waddr_b,
    input  logic          i_issue_en,
    input  logic [AW-1:0] i_issue_addr,
    input  logic [AW-1:0] i_raddr_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic          o_pend_a,
    output logic          o_pend_b,
    output logic          o_busy
);
    localparam int NREG = 1 << AW;

    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;

    assign w_set = NREG'(i_issue_en) << i_issue_addr;
    assign w_clr = (NREG'(i_we_a) << i_waddr_a) | (NREG'(i_we_b) << i_waddr_b);

    // writes retire pending bits, a same-cycle issue re-arms them
    always_ff @(posedge i_clk) begin
        if (i_rst) r_pend <= '0;
        else       r_pend <= (r_pend & ~w_clr) | w_set;
    end

    assign o_pend_a = r_pend[i_raddr_a];
    assign o_pend_b = r_pend[i_raddr_b];
    assign o_busy   = |r_pend;
endmodule

// File: rtl/param_reg_file.sv
// param_reg_file: dual-write register file with optional forwarding, taps, status and scoreboard
module param_reg_file
    import regfile_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int AW     = DEF_AW,
    parameter int SW     = DEF_SW,
    parameter bit BYPASS = 1'b1,
    parameter int TAP0   = DEF_TAP0,
    parameter int TAP1   = DEF_TAP1,
    parameter int TAP2   = DEF_TAP2
) (
    input logic             Clk,
    input logic             Reset,
    param_reg_file_if.slave bus
);
    localparam int NREG = 1 << AW;

    logic [W-1:0]  r_mem [NREG];
    logic [SW-1:0] r_s;
    logic          w_we_a;
    logic          w_we_b;
    logic [AW-1:0] w_waddr_a;
    logic [AW-1:0] w_waddr_b;
    logic [W-1:0]  w_wdata_a;
    logic [W-1:0]  w_wdata_b;

    assign w_we_a    = bus.WeA;
    assign w_waddr_a = bus.WaddrA;
    assign w_wdata_a = bus.WdataA;
    assign w_waddr_b = bus.WaddrB;
    assign w_wdata_b = bus.WdataB;
    // port B yields to port A when both target the same register
    assign w_we_b    = bus.WeB && !(bus.WeA && bus.WaddrA == bus.WaddrB);

    function automatic logic [W-1:0] f_read(input logic [AW-1:0] a);
        return (BYPASS && w_we_a && w_waddr_a == a) ? w_wdata_a :
               (BYPASS && w_we_b && w_waddr_b == a) ? w_wdata_b : r_mem[a];
    endfunction

    // register array update, reset clears everything and overrides writes
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
        end else begin
            if (w_we_a) r_mem[w_waddr_a] <= w_wdata_a;
            if (w_we_b) r_mem[w_waddr_b] <= w_wdata_b;
        end
    end

    // status register loads on StEn, otherwise holds
    always_ff @(posedge Clk) begin
        if (Reset)         r_s <= '0;
        else if (bus.StEn) r_s <= bus.StIn;
    end

    assign bus.DataOutA = f_read(bus.RaddrA);
    assign bus.DataOutB = f_read(bus.RaddrB);
    assign bus.Tap0     = f_read(AW'(TAP0));
    assign bus.Tap1     = f_read(AW'(TAP1));
    assign bus.Tap2     = f_read(AW'(TAP2));
    assign bus.S        = r_s;

    rf_scoreboard #(.AW(AW)) u_sb (
        .i_clk        (Clk),
        .i_rst        (Reset),
        .i_we_a       (bus.WeA),
        .i_waddr_a    (bus.WaddrA),
        .i_we_b       (bus.WeB),
        .i_waddr_b    (bus.WaddrB),
        .i_issue_en   (bus.IssueEn),
        .i_issue_addr (bus.IssueAddr),
        .i_raddr_a    (bus.RaddrA),
        .i_raddr_b    (bus.RaddrB),
        .o_pend_a     (bus.PendA),
        .o_pend_b     (bus.PendB),
        .o_busy       (bus.Busy)
    );
endmodule

// File: tb/tb_param_reg_file.sv
// tb_param_reg_file: table-driven vectors with an expected-value queue, plus no-bypass sequence
module tb_param_reg_file;
    import regfile_pkg::*;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    param_reg_file_if #(.W(16), .AW(3), .SW(2)) bus ();
    param_reg_file_if #(.W(16), .AW(3), .SW(2)) bus_nb ();

    param_reg_file #(.BYPASS(1'b1)) u_dut (.Clk(Clk), .Reset(Reset), .bus(bus));
    param_reg_file #(.BYPASS(1'b0)) u_nb  (.Clk(Clk), .Reset(Reset), .bus(bus_nb));

    typedef struct {
        logic [15:0] a, b, t1, t2;
        logic        pa, pb, busy;
        logic [1:0]  s;
    } exp_t;

    typedef struct {
        logic        rst, wea;
        logic [2:0]  wa;
        logic [15:0] da;
        logic        web;
        logic [2:0]  wb;
        logic [15:0] db;
        logic        ste;
        logic [1:0]  st;
        logic        iss;
        logic [2:0]  ia, ra, rb;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input int rst, wea, wa, da, web, wb, db, ste, st, iss, ia,
                                ra, rb, ea, eb, et1, et2, epa, epb, ebz, es);
        vec_t v;
        v.rst = 1'(rst); v.wea = 1'(wea); v.wa = 3'(wa); v.da = 16'(da);
        v.web = 1'(web); v.wb = 3'(wb); v.db = 16'(db);
        v.ste = 1'(ste); v.st = 2'(st); v.iss = 1'(iss); v.ia = 3'(ia);
        v.ra = 3'(ra); v.rb = 3'(rb);
        v.e.a = 16'(ea); v.e.b = 16'(eb); v.e.t1 = 16'(et1); v.e.t2 = 16'(et2);
        v.e.pa = 1'(epa); v.e.pb = 1'(epb); v.e.busy = 1'(ebz); v.e.s = 2'(es);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        Reset         = v.rst;
        bus.WeA       = v.wea; bus.WaddrA = v.wa; bus.WdataA = v.da;
        bus.WeB       = v.web; bus.WaddrB = v.wb; bus.WdataB = v.db;
        bus.StEn      = v.ste; bus.StIn   = v.st;
        bus.IssueEn   = v.iss; bus.IssueAddr = v.ia;
        bus.RaddrA    = v.ra;  bus.RaddrB = v.rb;
    endtask

    task automatic check_top(input string tag);
        exp_t e;
        e = q.pop_front();
        chk({tag, ".DataOutA"}, bus.DataOutA, e.a);
        chk({tag, ".DataOutB"}, bus.DataOutB, e.b);
        chk({tag, ".Tap1"}, bus.Tap1, e.t1);
        chk({tag, ".Tap2"}, bus.Tap2, e.t2);
        chk({tag, ".PendA"}, 16'(bus.PendA), 16'(e.pa));
        chk({tag, ".PendB"}, 16'(bus.PendB), 16'(e.pb));
        chk({tag, ".Busy"}, 16'(bus.Busy), 16'(e.busy));
        chk({tag, ".S"}, 16'(bus.S), 16'(e.s));
    endtask

    task automatic nb_drive(input logic we, input logic [15:0] d);
        bus_nb.WeA = we; bus_nb.WaddrA = 3'd3; bus_nb.WdataA = d; bus_nb.RaddrA = 3'd3;
    endtask

    initial begin
        vec_t idle;
        idle = mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        drive(idle);
        Reset = 1'b1;
        bus_nb.WeA = 0; bus_nb.WaddrA = 0; bus_nb.WdataA = 0;
        bus_nb.WeB = 0; bus_nb.WaddrB = 0; bus_nb.WdataB = 0;
        bus_nb.StEn = 0; bus_nb.StIn = 0; bus_nb.IssueEn = 0; bus_nb.IssueAddr = 0;
        bus_nb.RaddrA = 0; bus_nb.RaddrB = 0;

        // rst wea wa da web wb db ste st iss ia ra rb | a b t1 t2 pa pb busy s
        vecs.push_back(mk(0,0,0,0,      0,0,0,      0,0,0,0,0,1, 0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,      0,0,0,0,2,7, 0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,      0,0,0,0,3,5, 0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,2,'h1234, 1,6,'hBEEF, 0,0,0,0,2,6, 'h1234,'hBEEF,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,      0,0,0,0,2,6, 'h1234,'hBEEF,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,5,1,      1,5,2,      0,0,0,0,5,5, 1,1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,      0,0,0,0,5,2, 1,'h1234,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,      0,0,1,4,4,4, 0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,      0,0,0,0,4,0, 0,0,0,0,1,0,1,0));
        vecs.push_back(mk(0,1,4,'hCC,   0,0,0,      0,0,1,4,4,4, 'hCC,'hCC,0,'hCC,1,1,1,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,      0,0,0,0,4,3, 'hCC,0,0,'hCC,1,0,1,0));
        vecs.push_back(mk(0,1,4,'hDDD,  0,0,0,      0,0,0,0,4,1, 'hDDD,0,0,'hDDD,1,0,1,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,      0,0,0,0,4,4, 'hDDD,'hDDD,0,'hDDD,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,      1,1,0,0,0,0, 0,0,0,'hDDD,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,      0,0,0,      0,0,0,0,0,0, 0,0,0,'hDDD,0,0,0,1));
        vecs.push_back(mk(0,1,1,'h7777, 1,3,'hAA,   0,0,0,0,1,3, 'h7777,'hAA,'hAA,'hDDD,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,      0,0,0,      1,2,1,1,1,3, 'h7777,'hAA,'hAA,'hDDD,0,0,0,1));
        vecs.push_back(mk(1,1,1,'h1111, 0,0,0,      1,3,1,2,1,3, 'h1111,'hAA,'hAA,'hDDD,1,0,1,2));
        vecs.push_back(mk(0,0,0,0,      0,0,0,      0,0,0,0,1,3, 0,0,0,0,0,0,0,0));

        @(negedge Clk);
        @(negedge Clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge Clk);
            drive(vecs[i]);
            q.push_back(vecs[i].e);
            #1;
            check_top($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            reg_addr_t a;
            vec_t v;
            a = reg_addr_t'(i);
            v = idle;
            v.ra = a;
            v.rb = ~a;
            @(negedge Clk);
            drive(v);
            q.push_back(v.e);
            #1;
            check_top($sformatf("rd%0d", i));
        end

        @(negedge Clk);
        nb_drive(1'b1, 16'h00AA);
        #1;
        chk("nb.first.DataOutA", bus_nb.DataOutA, 16'h0000);
        chk("nb.first.Tap1", bus_nb.Tap1, 16'h0000);
        @(negedge Clk);
        nb_drive(1'b1, 16'h0055);
        #1;
        chk("nb.hold.DataOutA", bus_nb.DataOutA, 16'h00AA);
        chk("nb.hold.Tap1", bus_nb.Tap1, 16'h00AA);
        @(negedge Clk);
        nb_drive(1'b0, 16'h0000);
        #1;
        chk("nb.after.DataOutA", bus_nb.DataOutA, 16'h0055);
        chk("nb.after.Tap1", bus_nb.Tap1, 16'h0055);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/param_reg_file.md
PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 Parameter W, default 16: register data width in bits.
REQ-002 Parameter AW, default 3: address width; NREG = 2**AW registers.
REQ-003 Parameter SW, default 2: status register width.
REQ-004 Parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding, 0 = reads return the pre-write value.
REQ-005 Parameters TAP0/TAP1/TAP2, defaults 0/3/4: register indices driven on the fixed tap outputs.
REQ-006 Clk  in  1  clock; all state updates on the rising edge.
REQ-007 Reset  in  1  reset, synchronous, active-high.
REQ-008 WeA / WaddrA / WdataA  in  1/AW/W  primary write port.
REQ-009 WeB / WaddrB / WdataB  in  1/AW/W  secondary write port (paired-result writes).
REQ-010 StEn / StIn  in  1/SW  status register write.
REQ-011 IssueEn / IssueAddr  in  1/AW  marks a register as awaiting a deferred (load) write.
REQ-012 RaddrA / RaddrB  in  AW/AW  read addresses.
REQ-013 DataOutA / DataOutB  out  W/W  read data.
REQ-014 Tap0 / Tap1 / Tap2  out  W each  contents of registers TAP0/TAP1/TAP2.
REQ-015 PendA / PendB  out  1/1  pending bit of RaddrA / RaddrB.
REQ-016 Busy  out  1  OR of all pending bits.
REQ-017 S  out  SW  status register.

Function
REQ-018 Reads are combinational; DataOutX = register[RaddrX], with a BYPASS override per REQ-022.
REQ-019 A write with WeA or WeB high updates register[WaddrX] with WdataX on the rising edge.
REQ-020 WeA and WeB high with WaddrA == WaddrB: port A's data is written and port B is dropped.
REQ-021 Different addresses on both ports: both are written in the same cycle.
REQ-022 When BYPASS=1 and RaddrX matches an active write address, DataOutX shows that write's data; port A takes priority per REQ-020. Taps forward the same way.
REQ-023 When BYPASS=0, DataOutX and the taps show only registered contents.
REQ-024 Scoreboard: each register has one pending bit. IssueEn sets pending[IssueAddr].
REQ-025 A write on either port clears pending[WaddrX].
REQ-026 IssueEn and a write to the same address in the same cycle: the pending bit ends up set, because issue wins.
REQ-027 IssueEn to an already-pending register leaves it pending; there is no count.
REQ-028 PendX reflects registered pending bits only; it is not bypassed.
REQ-029 Busy is high while any pending bit is set.
REQ-030 StEn loads S with StIn on the next edge; S is otherwise held.
REQ-031 Writes to registers and S take effect one edge after the enables are sampled; there is no internal pipeline.

Reset
REQ-032 Reset high at an edge clears every register, every pending bit, and S to 0.
REQ-033 Reset dominates all same-cycle writes, issues, and StEn.
REQ-034 Outputs after reset: DataOutA, DataOutB and the taps are 0 unless bypassed; PendA, PendB and Busy are 0; S = 0.
REQ-035 Reset asserted mid-pending discards the outstanding deferred writes; no write is replayed.

Structure
REQ-036 Package regfile_pkg holds the default W/AW/SW constants, the tap index constants, and typedef reg_addr_t = logic [AW-1:0].
REQ-037 The scoreboard is a sub-module, rf_scoreboard, that owns the pending bits, PendA, PendB and Busy.
REQ-038 The register array, the write arbitration and the bypass mux live in param_reg_file.

Verification
REQ-039 Reset, then read all addresses -> all 0, Busy = 0, S = 0.
REQ-040 WeA to R2 = 0x1234, WeB to R6 = 0xBEEF in the same cycle -> next cycle R2 = 0x1234 and R6 = 0xBEEF.
REQ-041 WeA (R5 = 0x0001) and WeB (R5 = 0x0002) in the same cycle -> R5 = 0x0001. With RaddrA = 5 in that cycle and BYPASS=1, DataOutA = 0x0001.
REQ-042 BYPASS=0, R3 = 0x00AA, write R3 = 0x0055 with RaddrA = 3 -> DataOutA = 0x00AA that cycle, then 0x0055. Tap1 follows the same sequence.
REQ-043 IssueEn R4 -> PendA (RaddrA = 4) = 1 and Busy = 1. WeA to R4 plus IssueEn R4 in the same cycle -> R4 updated and still pending. Then WeA to R4 alone -> pending cleared, Busy = 0.
REQ-044 R1 = 0x7777, IssueEn R1, StEn with StIn = 2'b10, then Reset -> R1 = 0, Busy = 0, S = 0.
